// File: rtl/can_pkg.sv
// Shared CAN definitions for the bit destuffer.
// Contents: FSM state type, line-level constants and default timing parameters.
package can_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSof,
    StFrame
  } can_state_e;

  localparam logic CAN_RECESSIVE = 1'b1;
  localparam logic CAN_DOMINANT  = 1'b0;

  localparam int unsigned DEF_STUFF_LEN = 5;
  localparam int unsigned DEF_IDLE_BITS = 11;

endpackage

// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer.
// Samples rx on each rising edge of baud, tracks bus idle, detects start of frame,
// removes stuff bits and flags stuff-rule violations and loss of clock lock.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rx                synchronised CAN line (1 = recessive)
//   baud              recovered bit clock; rising edge is the sample point
//   lock              clock-recovery lock flag
//   destuff_en        high while stuffed fields are in progress
//   bit_out/bit_valid destuffed data bit and its one-clk qualifier
//   sof               pulse with the bit_valid of the start-of-frame bit
//   stuff_err         pulse on a stuff-rule violation
//   frame_abort       pulse when lock is lost during a frame
//   bus_idle          level, high while waiting for start of frame
module can_bit_destuffer
  import can_pkg::*;
#(
  parameter int unsigned STUFF_LEN = DEF_STUFF_LEN,
  parameter int unsigned IDLE_BITS = DEF_IDLE_BITS
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic baud,
  input  logic lock,
  input  logic destuff_en,
  output logic bit_out,
  output logic bit_valid,
  output logic sof,
  output logic stuff_err,
  output logic frame_abort,
  output logic bus_idle
);

  localparam int unsigned RunW  = $clog2(STUFF_LEN + 1);
  localparam int unsigned IdleW = $clog2(IDLE_BITS + 1);
  localparam logic [RunW-1:0]  RunMax  = RunW'(STUFF_LEN);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_BITS);

  can_state_e       state_q, state_d;
  logic [RunW-1:0]  run_cnt_q, run_cnt_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             run_pol_q, run_pol_d;
  logic             baud_q;
  // Low for the first clk after reset so a baud already high then is not a sample.
  logic             armed_q;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             sof_q, sof_d;
  logic             stuff_err_q, stuff_err_d;
  logic             frame_abort_q, frame_abort_d;
  logic             bus_idle_q, bus_idle_d;
  logic             sample_evt;

  assign sample_evt = baud & ~baud_q & armed_q;

  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    run_pol_d     = run_pol_q;
    idle_cnt_d    = idle_cnt_q;
    bit_out_d     = bit_out_q;
    bit_valid_d   = 1'b0;
    sof_d         = 1'b0;
    stuff_err_d   = 1'b0;
    frame_abort_d = 1'b0;

    if (sample_evt) begin
      if (!lock) begin
        idle_cnt_d = '0;
        if (state_q == StFrame) begin
          frame_abort_d = 1'b1;
          state_d       = StIdle;
          run_cnt_d     = '0;
        end
      end else begin
        if (rx == CAN_RECESSIVE) begin
          if (idle_cnt_q != IdleMax) idle_cnt_d = idle_cnt_q + 1'b1;
        end else begin
          idle_cnt_d = '0;
        end

        unique case (state_q)
          StIdle: begin
            if (idle_cnt_d == IdleMax) state_d = StWaitSof;
          end
          StWaitSof: begin
            if (rx == CAN_DOMINANT) begin
              state_d     = StFrame;
              bit_out_d   = CAN_DOMINANT;
              bit_valid_d = 1'b1;
              sof_d       = 1'b1;
              run_cnt_d   = RunW'(1);
              run_pol_d   = CAN_DOMINANT;
            end
          end
          StFrame: begin
            if (!destuff_en) begin
              // Unstuffed field: also wins over a stuff bit that was due here.
              bit_out_d   = rx;
              bit_valid_d = 1'b1;
              run_cnt_d   = '0;
            end else if (run_cnt_q == RunMax) begin
              if (rx == run_pol_q) begin
                stuff_err_d = 1'b1;
                state_d     = StIdle;
                idle_cnt_d  = '0;
                run_cnt_d   = '0;
              end else begin
                run_cnt_d = RunW'(1);
                run_pol_d = rx;
              end
            end else begin
              bit_out_d   = rx;
              bit_valid_d = 1'b1;
              // A zero count means destuff_en just rose: restart the run here.
              if (run_cnt_q != '0 && rx == run_pol_q) begin
                run_cnt_d = run_cnt_q + 1'b1;
              end else begin
                run_cnt_d = RunW'(1);
                run_pol_d = rx;
              end
            end
            if (state_d == StFrame && idle_cnt_d == IdleMax) begin
              state_d   = StWaitSof;
              run_cnt_d = '0;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    bus_idle_d = (state_d == StWaitSof);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      run_cnt_q     <= '0;
      run_pol_q     <= 1'b0;
      idle_cnt_q    <= '0;
      baud_q        <= 1'b0;
      armed_q       <= 1'b0;
      bit_out_q     <= 1'b1;
      bit_valid_q   <= 1'b0;
      sof_q         <= 1'b0;
      stuff_err_q   <= 1'b0;
      frame_abort_q <= 1'b0;
      bus_idle_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      run_pol_q     <= run_pol_d;
      idle_cnt_q    <= idle_cnt_d;
      baud_q        <= baud;
      armed_q       <= 1'b1;
      bit_out_q     <= bit_out_d;
      bit_valid_q   <= bit_valid_d;
      sof_q         <= sof_d;
      stuff_err_q   <= stuff_err_d;
      frame_abort_q <= frame_abort_d;
      bus_idle_q    <= bus_idle_d;
    end
  end

  assign bit_out     = bit_out_q;
  assign bit_valid   = bit_valid_q;
  assign sof         = sof_q;
  assign stuff_err   = stuff_err_q;
  assign frame_abort = frame_abort_q;
  assign bus_idle    = bus_idle_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Scoreboard bench for can_bit_destuffer: stimulus pushes expected pulse events,
// a negedge monitor pops and compares whenever the DUT raises any pulse output.
module tb_can_bit_destuffer;

  localparam logic [1:0] EvBit   = 2'd0;
  localparam logic [1:0] EvStuff = 2'd1;
  localparam logic [1:0] EvAbort = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic       b;
    logic       s;
  } ev_t;

  logic clk = 1'b0;
  logic rst, rx, baud, lock, destuff_en;
  logic bit_out, bit_valid, sof, stuff_err, frame_abort, bus_idle;

  int n_cmp = 0;
  int n_bad = 0;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  can_bit_destuffer #(
    .STUFF_LEN(5),
    .IDLE_BITS(11)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .baud       (baud),
    .lock       (lock),
    .destuff_en (destuff_en),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .sof        (sof),
    .stuff_err  (stuff_err),
    .frame_abort(frame_abort),
    .bus_idle   (bus_idle)
  );

  // Monitor: any pulse output must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (bit_valid || sof || stuff_err || frame_abort)) begin
      ev_t act;
      ev_t exp;
      act.kind = bit_valid ? EvBit : (stuff_err ? EvStuff : EvAbort);
      act.b    = bit_valid ? bit_out : 1'b0;
      act.s    = sof;
      n_cmp++;
      if ((bit_valid + stuff_err + frame_abort) != 1) begin
        n_bad++;
        $display("FAIL pulse_overlap: valid=%0b err=%0b abort=%0b sof=%0b at %0t",
                 bit_valid, stuff_err, frame_abort, sof, $time);
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got kind=%0d b=%0b s=%0b, expected none at %0t",
                 act.kind, act.b, act.s, $time);
      end else begin
        exp = exp_q.pop_front();
        if (act != exp) begin
          n_bad++;
          $display("FAIL event: got kind=%0d b=%0b s=%0b, expected kind=%0d b=%0b s=%0b at %0t",
                   act.kind, act.b, act.s, exp.kind, exp.b, exp.s, $time);
        end
      end
    end
  end

  task automatic exp_bit(input logic b, input logic s);
    ev_t e;
    e.kind = EvBit;
    e.b    = b;
    e.s    = s;
    exp_q.push_back(e);
  endtask

  task automatic exp_ev(input logic [1:0] k);
    ev_t e;
    e.kind = k;
    e.b    = 1'b0;
    e.s    = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // One sample point: rising baud seen at the next posedge, then baud low for 2 clks.
  task automatic smp(input logic r, input logic lk, input logic de);
    rx         = r;
    lock       = lk;
    destuff_en = de;
    baud       = 1'b1;
    @(posedge clk);
    #1;
    baud = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle_run(input int n);
    for (int i = 0; i < n; i++) smp(1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    rst        = 1'b1;
    baud       = 1'b1;
    rx         = 1'b1;
    lock       = 1'b1;
    destuff_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bit_out", bit_out, 1'b1);
    chk("rst_bit_valid", bit_valid, 1'b0);
    chk("rst_sof", sof, 1'b0);
    chk("rst_stuff_err", stuff_err, 1'b0);
    chk("rst_frame_abort", frame_abort, 1'b0);
    chk("rst_bus_idle", bus_idle, 1'b0);

    // Release with baud already high: that first clk must not sample.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    baud = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Bus idle after exactly 11 recessive samples, then SOF.
    idle_run(10);
    chk("idle_after_10", bus_idle, 1'b0);
    idle_run(1);
    chk("idle_after_11", bus_idle, 1'b1);
    exp_bit(1'b0, 1'b1);
    smp(1'b0, 1'b1, 1'b1);
    chk("idle_drop_at_sof", bus_idle, 1'b0);

    // Four 0s reach the stuff limit; stuff 1 is dropped; then data 1.
    for (int i = 0; i < 4; i++) begin
      exp_bit(1'b0, 1'b0);
      smp(1'b0, 1'b1, 1'b1);
    end
    smp(1'b1, 1'b1, 1'b1);
    exp_bit(1'b1, 1'b0);
    smp(1'b1, 1'b1, 1'b1);
    // Three more 1s make a run of five; stuff 0 dropped; then data 0.
    for (int i = 0; i < 3; i++) begin
      exp_bit(1'b1, 1'b0);
      smp(1'b1, 1'b1, 1'b1);
    end
    smp(1'b0, 1'b1, 1'b1);
    exp_bit(1'b0, 1'b0);
    smp(1'b0, 1'b1, 1'b1);

    // Destuffing off: six 1s all pass, then a 0 to clear the idle count.
    for (int i = 0; i < 6; i++) begin
      exp_bit(1'b1, 1'b0);
      smp(1'b1, 1'b1, 1'b0);
    end
    exp_bit(1'b0, 1'b0);
    smp(1'b0, 1'b1, 1'b0);

    // Destuffing back on: run restarts, five 0s pass, sixth 0 is a stuff error.
    for (int i = 0; i < 5; i++) begin
      exp_bit(1'b0, 1'b0);
      smp(1'b0, 1'b1, 1'b1);
    end
    exp_ev(EvStuff);
    smp(1'b0, 1'b1, 1'b1);
    chk("idle_after_stuff_err", bus_idle, 1'b0);

    // destuff_en low at the stuff position: sample is data, no error.
    idle_run(11);
    chk("idle_frame_b", bus_idle, 1'b1);
    exp_bit(1'b0, 1'b1);
    smp(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      exp_bit(1'b0, 1'b0);
      smp(1'b0, 1'b1, 1'b1);
    end
    exp_bit(1'b0, 1'b0);
    smp(1'b0, 1'b1, 1'b0);

    // Lock loss at the third frame sample aborts; lock low in WAIT_SOF is ignored.
    exp_ev(EvAbort);
    smp(1'b0, 1'b0, 1'b0);
    idle_run(11);
    chk("idle_frame_c", bus_idle, 1'b1);
    smp(1'b0, 1'b0, 1'b1);
    chk("nolock_wait_sof_idle", bus_idle, 1'b1);
    exp_bit(1'b0, 1'b1);
    smp(1'b0, 1'b1, 1'b1);
    exp_bit(1'b1, 1'b0);
    smp(1'b1, 1'b1, 1'b1);
    exp_ev(EvAbort);
    smp(1'b1, 1'b0, 1'b1);
    chk("idle_after_abort", bus_idle, 1'b0);
    idle_run(10);
    chk("abort_idle_10", bus_idle, 1'b0);
    idle_run(1);
    chk("abort_idle_11", bus_idle, 1'b1);

    // Reset mid-frame, asserted just after a sample edge: pulse is killed at once.
    exp_bit(1'b0, 1'b1);
    smp(1'b0, 1'b1, 1'b1);
    rx   = 1'b0;
    baud = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_bit_out", bit_out, 1'b1);
    chk("midrst_bit_valid", bit_valid, 1'b0);
    chk("midrst_sof", sof, 1'b0);
    chk("midrst_bus_idle", bus_idle, 1'b0);
    baud = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_run(10);
    chk("rst_idle_10", bus_idle, 1'b0);
    idle_run(1);
    chk("rst_idle_11", bus_idle, 1'b1);

    repeat (4) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: %0d expected events never seen", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/can_bit_destuffer.md
CAN_BIT_DESTUFFER -- requirements
Module: can_bit_destuffer

Interface
REQ-001 Parameter STUFF_LEN, default 5: count of identical consecutive bits after which a stuff bit is expected.
REQ-002 Parameter IDLE_BITS, default 11: count of consecutive recessive samples that declares bus idle.
REQ-003 clk  input  1  system clock; one clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  CAN line, already synchronised to clk; 1 = recessive.
REQ-006 baud  input  1  recovered bit clock from the upstream clock-recovery stage; rising edge marks the sample point.
REQ-007 lock  input  1  upstream clock-recovery lock flag.
REQ-008 destuff_en  input  1  from the downstream frame decoder; high while stuffed fields are in progress.
REQ-009 bit_out  output  1  destuffed data bit.
REQ-010 bit_valid  output  1  one-clk pulse qualifying bit_out.
REQ-011 sof  output  1  one-clk pulse coincident with the bit_valid of the start-of-frame bit.
REQ-012 stuff_err  output  1  one-clk pulse on a stuff-rule violation.
REQ-013 frame_abort  output  1  one-clk pulse when lock is low at a sample point in FRAME.
REQ-014 bus_idle  output  1  level; high while in WAIT_SOF.

Function
REQ-015 Sample event: the clk edge at which baud=1 and registered baud_q=0; rx is sampled at that edge; all outputs are registered there, so latency is 1 clk.
REQ-016 States: IDLE, WAIT_SOF, FRAME; the FSM changes state only on sample events.
REQ-017 The idle counter increments on each recessive sample, clears on each dominant sample, and saturates at IDLE_BITS.
REQ-018 IDLE -> WAIT_SOF when the idle counter reaches IDLE_BITS; bus_idle rises with the same registered update.
REQ-019 WAIT_SOF: a dominant sample -> FRAME; bit_out=0, bit_valid=1, sof=1; run counter=1; run polarity=0.
REQ-020 FRAME with destuff_en=1 and run counter < STUFF_LEN: output the sample; if it equals the run polarity, run+1, else run=1 and polarity=sample.
REQ-021 FRAME with destuff_en=1 and run counter = STUFF_LEN: the sample is a stuff bit; bit_valid stays 0.
REQ-022 Stuff bit opposite to the run polarity: run=1, polarity=sample.
REQ-023 Stuff bit equal to the run polarity: stuff_err=1, -> IDLE, idle counter=0.
REQ-024 FRAME with destuff_en=0: every sample is output; the run counter holds at 0; no stuff check is made.
REQ-025 If destuff_en falls at the sample where a stuff bit is due, that sample is treated as data (REQ-024 takes precedence).
REQ-026 destuff_en rising: the run counter restarts at 1 with polarity = the first sample.
REQ-027 In any state, reaching IDLE_BITS recessive samples -> WAIT_SOF, which ends the frame.
REQ-028 lock=0 at a sample in FRAME: frame_abort=1, no bit_valid, -> IDLE, idle counter=0.
REQ-029 lock=0 in IDLE or WAIT_SOF: samples are ignored and the idle counter is cleared.
REQ-030 The run counter is $clog2(STUFF_LEN+1) bits wide; the idle counter is $clog2(IDLE_BITS+1) bits wide; neither wraps.
REQ-031 Between sample events all pulse outputs are 0.

Reset
REQ-032 While rst is high: state=IDLE; counters=0; baud_q=0; bit_out=1; bit_valid=0; sof=0; stuff_err=0; frame_abort=0; bus_idle=0.
REQ-033 Reset asserted mid-frame aborts immediately with no pulse; after release, IDLE_BITS recessive samples are required before WAIT_SOF.
REQ-034 If baud is high on the first clk after reset, that clk does not count as a sample event.

Structure
REQ-035 A shared package can_pkg holds the state typedef, the CAN_RECESSIVE/CAN_DOMINANT constants and the default STUFF_LEN/IDLE_BITS.
REQ-036 The block is a single module with no sub-modules; baud edge detection is inline.

Verification
REQ-037 Scenario: 11 recessive samples then dominant -> bus_idle high after sample 11; at sample 12, sof=1, bit_valid=1, bit_out=0.
REQ-038 Scenario: after SOF, data 0,0,0,0 then stuff 1 then 1 -> four bit_valid pulses of 0, none for the stuff bit, then bit_out=1.
REQ-039 Scenario: after SOF, four more 0s then 0 at the stuff position -> stuff_err pulse, state IDLE, bus_idle=0.
REQ-040 Scenario: destuff_en=0 and six 1s -> six bit_valid pulses; no stuff_err.
REQ-041 Scenario: lock=0 at the third frame sample -> frame_abort pulse, no bit_valid, 11 recessive samples needed to regain bus_idle.
REQ-042 Scenario: rst pulsed mid-frame -> all outputs at reset values within the same clk; no pulses.
